// File: rtl/platform_rom_arbiter_pkg.sv
// Shared constants and types for the sprite ROM sharing logic.
package platform_rom_arbiter_pkg;

  // Geometry of the platform sprite ROMs.
  localparam int SPRITE_ADDR_W = 10;
  localparam int SPRITE_DATA_W = 24;

  // One RGB888 colour word as stored in a sprite ROM.
  typedef logic [SPRITE_DATA_W-1:0] rgb888_t;

  // Round-robin successor of idx in a ring of n slots.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/platform_rom_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found when searching
// upward from rr_ptr (modulo N). Purely combinational; the caller owns the
// pointer register so the same block can serve other sprite ROM ports.
module platform_rom_arbiter_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] cand_idx;

  // Search the ring starting at rr_ptr; the first asserted request wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_idx    = '0;
    for (int off = 0; off < N; off++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + off) % N);
      if (enable && !grant_valid && req[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/platform_rom_arbiter.sv
// Shares one synchronous-read sprite ROM port between NUM_REQ pixel
// fetchers plus a write channel with strict priority, and returns each read
// word tagged with the id of the requester that issued it.
//
// Handshakes: a requester holds req[i] (and its address slot) until it sees
// grant[i]=1 at a rising edge; that edge is the transfer, and req still high
// afterwards is a new request. The write channel works the same way with
// wr_valid/wr_ready, except wr_ready is granted whenever wr_valid is high
// outside reset. Responses (rsp_valid) have no ready: the consumer must take
// every word in the cycle it is presented.
module platform_rom_arbiter
  import platform_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = SPRITE_ADDR_W,
  parameter int DATA_W      = SPRITE_DATA_W,
  parameter int ROM_LATENCY = 1,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      wr_valid,
  input  logic [ADDR_W-1:0]         wr_address,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ready,
  output logic                      rom_we,
  output logic [ADDR_W-1:0]         rom_write_address,
  output logic [ADDR_W-1:0]         rom_read_address,
  output logic [DATA_W-1:0]         rom_data_in,
  input  logic [DATA_W-1:0]         rom_data_out,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [ROM_LATENCY-1:0] vld_q, vld_d;
  logic [ID_W-1:0]        id_q [ROM_LATENCY];
  logic [ID_W-1:0]        id_d [ROM_LATENCY];
  logic [DATA_W-1:0]      hold_q, hold_d;

  logic                   arb_en;
  logic                   arb_valid;
  logic [ID_W-1:0]        arb_idx;

  // Reads only compete when neither reset nor a write owns the port.
  assign arb_en = ~Reset & ~wr_valid;

  platform_rom_arbiter_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req         (req),
    .rr_ptr      (rr_ptr_q),
    .enable      (arb_en),
    .grant       (grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Write channel: accepted in the same cycle it is offered.
  always_comb begin
    wr_ready          = wr_valid & ~Reset;
    rom_we            = wr_valid & ~Reset;
    rom_write_address = wr_address;
    rom_data_in       = wr_data;
  end

  // Read address: the granted slot, otherwise the last address presented.
  always_comb begin
    rom_read_address = rd_addr_q;
    if (arb_valid) begin
      rom_read_address = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    end
  end

  // Next state: pointer advance, address hold, in-flight {valid,id} shift
  // register and the rsp_data hold value.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (arb_valid) begin
      rr_ptr_d = ID_W'(wrap_inc(int'(arb_idx), NUM_REQ));
    end
    rd_addr_d = rom_read_address;
    vld_d     = vld_q;
    id_d      = id_q;
    vld_d[0]  = arb_valid;
    id_d[0]   = arb_idx;
    for (int j = 1; j < ROM_LATENCY; j++) begin
      vld_d[j] = vld_q[j-1];
      id_d[j]  = id_q[j-1];
    end
    hold_d = rsp_valid ? rom_data_out : hold_q;
  end

  // State registers; reset drops every in-flight read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_q  <= '0;
      rd_addr_q <= '0;
      vld_q     <= '0;
      hold_q    <= '0;
      for (int j = 0; j < ROM_LATENCY; j++) begin
        id_q[j] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= vld_d;
      hold_q    <= hold_d;
      id_q      <= id_d;
    end
  end

  // The tail of the shift register lines up with the ROM output word.
  assign rsp_valid = vld_q[ROM_LATENCY-1];
  assign rsp_id    = id_q[ROM_LATENCY-1];
  assign rsp_data  = rsp_valid ? rom_data_out : hold_q;

endmodule

// File: tb/tb_platform_rom_arbiter.sv
// Bench for platform_rom_arbiter: three instances (ROM_LATENCY 1,2,3) share
// one stimulus stream, each with its own behavioural ROM, all compared every
// cycle against a reference model built from the arbitration rules.
module tb_platform_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 24;
  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req        = '0;
  logic [N*AW-1:0] req_addr   = '0;
  logic            wr_valid   = 1'b0;
  logic [AW-1:0]   wr_address = '0;
  logic [DW-1:0]   wr_data    = '0;

  logic [N-1:0]  grant     [NI];
  logic          wr_ready  [NI];
  logic          rom_we    [NI];
  logic [AW-1:0] rom_wa    [NI];
  logic [AW-1:0] rom_ra    [NI];
  logic [DW-1:0] rom_din   [NI];
  logic [DW-1:0] rom_dout  [NI];
  logic          rsp_valid [NI];
  logic [1:0]    rsp_id    [NI];
  logic [DW-1:0] rsp_data  [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    logic [DW-1:0] mem  [1024];
    logic [DW-1:0] pipe [3];

    platform_rom_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(k + 1)
    ) u_dut (
      .Clk(clk), .Reset(rst), .req(req), .req_addr(req_addr),
      .grant(grant[k]), .wr_valid(wr_valid), .wr_address(wr_address),
      .wr_data(wr_data), .wr_ready(wr_ready[k]), .rom_we(rom_we[k]),
      .rom_write_address(rom_wa[k]), .rom_read_address(rom_ra[k]),
      .rom_data_in(rom_din[k]), .rom_data_out(rom_dout[k]),
      .rsp_valid(rsp_valid[k]), .rsp_id(rsp_id[k]), .rsp_data(rsp_data[k])
    );

    // Behavioural sprite ROM, preloaded with mem[a] = a*3.
    initial for (int a = 0; a < 1024; a++) mem[a] <= DW'(a * 3);

    always @(posedge clk) begin
      if (rom_we[k]) mem[rom_wa[k]] <= rom_din[k];
      pipe[0] <= mem[rom_ra[k]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign rom_dout[k] = pipe[k];
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [15:0]   due;
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q [NI][$];
  logic [DW-1:0] mdl_mem [1024];
  logic [DW-1:0] last_data [NI];
  int            mdl_ptr  = 0;
  int            cyc      = 0;
  bit            live     = 1'b0;
  bit            ra_known = 1'b0;
  logic [AW-1:0] last_ra  = '0;
  int            n_chk    = 0;
  int            n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compares every instance against the model for the current cycle, then
  // advances the model as the coming clock edge will.
  task automatic model_check();
    logic [N-1:0]  eg;
    logic [AW-1:0] ga;
    int            gi;
    bit            wr_act;
    exp_t          e;
    eg = '0;
    ga = '0;
    gi = -1;
    wr_act = wr_valid && !rst;
    if (!rst && !wr_valid) begin
      for (int o = 0; o < N; o++) begin
        int c = (mdl_ptr + o) % N;
        if (gi < 0 && req[c]) gi = c;
      end
    end
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ga = req_addr[gi*AW +: AW];
    end
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("grant[L%0d]", k + 1), 64'(grant[k]), 64'(eg));
      chk($sformatf("wr_ready[L%0d]", k + 1), 64'(wr_ready[k]), 64'(wr_act));
      chk($sformatf("rom_we[L%0d]", k + 1), 64'(rom_we[k]), 64'(wr_act));
      if (wr_act) begin
        chk($sformatf("rom_write_address[L%0d]", k + 1), 64'(rom_wa[k]), 64'(wr_address));
        chk($sformatf("rom_data_in[L%0d]", k + 1), 64'(rom_din[k]), 64'(wr_data));
      end
      if (gi >= 0)
        chk($sformatf("rom_read_address[L%0d]", k + 1), 64'(rom_ra[k]), 64'(ga));
      else if (ra_known)
        chk($sformatf("rom_read_address_hold[L%0d]", k + 1), 64'(rom_ra[k]), 64'(last_ra));
      if (live) begin
        if (exp_q[k].size() > 0 && int'(exp_q[k][0].due) == cyc) begin
          e = exp_q[k].pop_front();
          chk($sformatf("rsp_valid[L%0d]", k + 1), 64'(rsp_valid[k]), 64'(1));
          chk($sformatf("rsp_id[L%0d]", k + 1), 64'(rsp_id[k]), 64'(e.id));
          chk($sformatf("rsp_data[L%0d]", k + 1), 64'(rsp_data[k]), 64'(e.data));
          last_data[k] = e.data;
        end else begin
          chk($sformatf("rsp_valid_idle[L%0d]", k + 1), 64'(rsp_valid[k]), 64'(0));
          chk($sformatf("rsp_data_hold[L%0d]", k + 1), 64'(rsp_data[k]), 64'(last_data[k]));
        end
      end
    end
    if (live) begin
      chk("rr_ptr[L1]", 64'(g_dut[0].u_dut.rr_ptr_q), 64'(mdl_ptr));
      chk("rr_ptr[L2]", 64'(g_dut[1].u_dut.rr_ptr_q), 64'(mdl_ptr));
      chk("rr_ptr[L3]", 64'(g_dut[2].u_dut.rr_ptr_q), 64'(mdl_ptr));
    end
    if (rst) begin
      mdl_ptr  = 0;
      ra_known = 1'b0;
      live     = 1'b1;
      for (int k = 0; k < NI; k++) begin
        exp_q[k].delete();
        last_data[k] = '0;
      end
    end else if (wr_valid) begin
      mdl_mem[wr_address] = wr_data;
    end else if (gi >= 0) begin
      mdl_ptr  = (gi + 1) % N;
      last_ra  = ga;
      ra_known = 1'b1;
      for (int k = 0; k < NI; k++) begin
        e.due  = 16'(cyc + k + 1);
        e.id   = 2'(gi);
        e.data = mdl_mem[ga];
        exp_q[k].push_back(e);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cycle(input logic r, input logic [N-1:0] rq, input logic [N*AW-1:0] ra,
                           input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    @(posedge clk);
    cyc++;
    #1;
    rst = r; req = rq; req_addr = ra;
    wr_valid = wv; wr_address = wa; wr_data = wd;
    @(negedge clk);
    model_check();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [N-1:0]  req;
    logic          wv;
    logic [N-1:0]  g;
    logic [1:0]    ptr;
    logic          rv;
    logic [1:0]    rid;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [13];
  localparam logic [N*AW-1:0] STD_A = {10'd40, 10'd30, 10'd20, 10'd10};

  initial begin
    for (int a = 0; a < 1024; a++) mdl_mem[a] = DW'(a * 3);
    for (int k = 0; k < NI; k++) last_data[k] = '0;

    //        req      wv    grant    ptr  rv  rid   rdata (instance L1)
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0, 24'd0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd0, 24'd30};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd1, 24'd60};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd2, 24'd90};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd3, 24'd120};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 2'd0, 24'd30};
    tbl[6]  = '{4'b1001, 1'b0, 4'b1000, 2'd1, 1'b0, 2'd0, 24'd0};
    tbl[7]  = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd3, 24'd120};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b1, 2'd0, 24'd30};
    tbl[9]  = '{4'b0100, 1'b0, 4'b0100, 2'd1, 1'b0, 2'd0, 24'd0};
    tbl[10] = '{4'b0110, 1'b0, 4'b0010, 2'd3, 1'b1, 2'd2, 24'd90};
    tbl[11] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd1, 24'd60};
    tbl[12] = '{4'b0001, 1'b0, 4'b0001, 2'd3, 1'b1, 2'd2, 24'd90};

    // Reset, then five idle cycles.
    run_cycle(1'b1, '0, '0, 1'b0, '0, '0);
    run_cycle(1'b1, '0, '0, 1'b0, '0, '0);
    for (int t = 0; t < 5; t++) begin
      run_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      chk("idle_grant", 64'(grant[0]), 64'(0));
      chk("idle_rsp_valid", 64'(rsp_valid[0]), 64'(0));
      chk("idle_rr_ptr", 64'(g_dut[0].u_dut.rr_ptr_q), 64'(0));
    end

    // Table-driven arbitration sequence, addresses 10,20,30,40.
    for (int i = 0; i < 13; i++) begin
      run_cycle(1'b0, tbl[i].req, STD_A, tbl[i].wv, 10'd500, 24'h123456);
      chk($sformatf("tbl%0d_grant", i), 64'(grant[0]), 64'(tbl[i].g));
      chk($sformatf("tbl%0d_rr_ptr", i), 64'(g_dut[0].u_dut.rr_ptr_q), 64'(tbl[i].ptr));
      chk($sformatf("tbl%0d_rsp_valid", i), 64'(rsp_valid[0]), 64'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d_rsp_id", i), 64'(rsp_id[0]), 64'(tbl[i].rid));
        chk($sformatf("tbl%0d_rsp_data", i), 64'(rsp_data[0]), 64'(tbl[i].rdata));
      end
    end

    // Write priority over a pending read of the same address.
    for (int t = 0; t < 3; t++) begin
      run_cycle(1'b0, 4'b0010, {10'd0, 10'd0, 10'd20, 10'd0}, 1'b1, 10'd20, 24'hABCDEF);
      chk("wr_cycle_grant", 64'(grant[0]), 64'(0));
      chk("wr_cycle_ready", 64'(wr_ready[0]), 64'(1));
    end
    run_cycle(1'b0, 4'b0010, {10'd0, 10'd0, 10'd20, 10'd0}, 1'b0, '0, '0);
    chk("after_wr_grant", 64'(grant[0]), 64'(4'b0010));
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    chk("raw_rsp_valid", 64'(rsp_valid[0]), 64'(1));
    chk("raw_rsp_id", 64'(rsp_id[0]), 64'(1));
    chk("raw_rsp_data", 64'(rsp_data[0]), 64'(24'hABCDEF));

    // Wrap-around search: pointer at 3, only req[2].
    run_cycle(1'b0, 4'b0100, STD_A, 1'b0, '0, '0);
    run_cycle(1'b0, 4'b0100, STD_A, 1'b0, '0, '0);
    chk("wrap_grant", 64'(grant[0]), 64'(4'b0100));
    run_cycle(1'b0, '0, STD_A, 1'b0, '0, '0);
    chk("wrap_rr_ptr", 64'(g_dut[0].u_dut.rr_ptr_q), 64'(3));

    // Reset one cycle after a grant drops the in-flight read.
    run_cycle(1'b0, 4'b0001, STD_A, 1'b0, '0, '0);
    run_cycle(1'b1, 4'b1111, STD_A, 1'b0, '0, '0);
    chk("reset_grant", 64'(grant[1]), 64'(0));
    for (int t = 0; t < 4; t++) begin
      run_cycle(1'b0, '0, STD_A, 1'b0, '0, '0);
      chk("post_reset_rsp_valid_L2", 64'(rsp_valid[1]), 64'(0));
      chk("post_reset_rr_ptr_L2", 64'(g_dut[1].u_dut.rr_ptr_q), 64'(0));
    end

    // Back-to-back grants to ids 1 and 3 seen through ROM_LATENCY=3.
    run_cycle(1'b0, 4'b1010, STD_A, 1'b0, '0, '0);
    chk("b2b_grant1", 64'(grant[2]), 64'(4'b0010));
    run_cycle(1'b0, 4'b1010, STD_A, 1'b0, '0, '0);
    chk("b2b_grant3", 64'(grant[2]), 64'(4'b1000));
    for (int t = 2; t <= 6; t++) begin
      run_cycle(1'b0, '0, STD_A, 1'b0, '0, '0);
      chk($sformatf("b2b_rsp_valid_t%0d", t), 64'(rsp_valid[2]), 64'(t == 3 || t == 4));
      if (t == 3) chk("b2b_rsp_id_first", 64'(rsp_id[2]), 64'(1));
      if (t == 4) chk("b2b_rsp_id_second", 64'(rsp_id[2]), 64'(3));
    end

    // Randomized traffic over a small address window so writes hit reads.
    for (int t = 0; t < 400; t++) begin
      logic [N*AW-1:0] ra;
      logic            r;
      logic            wv;
      r  = ($urandom_range(0, 49) == 0);
      wv = ($urandom_range(0, 6) == 0);
      for (int s = 0; s < N; s++) ra[s*AW +: AW] = AW'(100 + $urandom_range(0, 15));
      run_cycle(r, N'($urandom_range(0, 15)), ra, wv,
                AW'(100 + $urandom_range(0, 15)), DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/platform_rom_arbiter.md
Name: platform_rom_arbiter

Overview:
- Shares the single synchronous-read port of one platform sprite ROM (24-bit colour words, 1-cycle read latency) between NUM_REQ requesters, e.g. per-platform pixel fetchers in the draw pipeline.
- Also carries one write channel, used for sprite reload or init, which has strict priority over reads.
- Sits between the requesters and the ROM instance.
- Returns each read word tagged with the id of the requester that issued it.

Parameters:
- NUM_REQ, 4, number of read requesters (2..8).
- ADDR_W, 10, ROM address width.
- DATA_W, 24, ROM word width (RGB888).
- ROM_LATENCY, 1, cycles from the address being presented to rom_data_out being valid (1..3).
- ID_W, $clog2(NUM_REQ), response tag width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester read request, held until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed read addresses; slot i is bits [i*ADDR_W +: ADDR_W].
- grant  out  NUM_REQ  one-hot pulse: request i accepted this cycle.
- wr_valid  in  1  write request.
- wr_address  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle.
- rom_we  out  1  to ROM we.
- rom_write_address  out  ADDR_W  to ROM write_address.
- rom_read_address  out  ADDR_W  to ROM read_address.
- rom_data_in  out  DATA_W  to ROM data input.
- rom_data_out  in  DATA_W  from ROM data output.
- rsp_valid  out  1  read data valid.
- rsp_id  out  ID_W  requester index for rsp_data.
- rsp_data  out  DATA_W  read word.

Behaviour:
- Clock and reset:
  - Single clock domain, Clk.
  - Reset is synchronous and active-high.
  - Reset values: rr_ptr=0; pipeline valid bits=0; rsp_valid=0; rsp_id=0; rsp_data=0.
  - grant, wr_ready and rom_we are combinational and are 0 while Reset=1.
- Write priority:
  - If wr_valid=1, then in that same cycle: wr_ready=1, rom_we=1, rom_write_address=wr_address, rom_data_in=wr_data.
  - No read is granted in a write cycle (grant=0).
  - Reads may be starved by continuous writes; this is intentional, because writes occur only during load or blanking.
- Read arbitration, only when wr_valid=0:
  - Round-robin search starts at index rr_ptr and proceeds upward modulo NUM_REQ.
  - The first i with req[i]=1 is granted: grant[i]=1, rom_read_address=req_addr slot i.
  - At most one read is granted per cycle; throughput is 1 word/cycle.
  - On any grant to i: rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - With no grant, rom_read_address holds its previous value and no response is scheduled.
  - A requester sees grant[i]=1 at a rising edge, then drops or changes req/req_addr for its next request. req is level-sensitive: holding req=1 after grant issues a new request.
- Response pipeline:
  - A ROM_LATENCY-deep shift register of {valid, id} tracks in-flight reads.
  - Read granted in cycle N → rsp_valid=1, rsp_id=i, rsp_data = word at the granted address in cycle N+ROM_LATENCY.
  - rsp_data is registered from rom_data_out (ROM_LATENCY=1: rom data is sampled at edge N+1 and presented in cycle N+1 on the same edge path; the pipeline aligns valid/id exactly to the ROM output).
  - Responses return in grant order; no backpressure on the rsp side.
  - rsp_data holds its last value when rsp_valid=0.
- Hazards:
  - A read granted after a write cycle to the same address returns the new data.
  - Write and read never share a cycle, so no collision case exists.
- Reset mid-operation: all in-flight reads are dropped (valid bits cleared), and no rsp_valid is issued for them after reset.
- Width rules: the unused upper id encodings (NUM_REQ not a power of 2) are never produced.

Decomposition:
- Shared package: DATA_W and ADDR_W constants for the sprite ROMs; the rgb888_t typedef (24-bit colour).
- Sub-module rr_arbiter:
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and a binary index.
  - Reusable for other sprite ROM sharing.
- The latency pipeline stays inline.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles → grant=0, rsp_valid=0, rr_ptr=0.
- req=4'b1111 held, addresses 10,20,30,40, ROM preloaded with mem[a]=a*3 → grants in order 0,1,2,3,0…, one per cycle; one cycle later each response appears with rsp_id=0,1,2,3 and rsp_data=30,60,90,120.
- wr_valid=1 for 3 cycles (addr 20, data 24'hABCDEF) while req=4'b0010 → grant=0 for those 3 cycles, wr_ready=1; then grant[1]=1 and rsp_data=24'hABCDEF, rsp_id=1.
- Only req[2]=1 with rr_ptr=3 → the search wraps and grant[2]=1 in the same cycle; rr_ptr becomes 3.
- Grant issued, Reset asserted in the next cycle with ROM_LATENCY=2 → no rsp_valid at any point after reset; rr_ptr=0.
- ROM_LATENCY=3, back-to-back grants to ids 1,3 → rsp_valid is high exactly 3 cycles after each grant, with ids 1 then 3.
